nios2_spi_slave: RTL and testbench

- SPI slave peripheral (mode 0: CPOL=0, CPHA=0; MSB first; 8-bit words) with the same CPU register-port style as the existing SPI master.
- Receives bytes from an external SPI master on MOSI and returns queued bytes on MISO.
- SCLK, SS_n and MOSI are asynchronous to clk. They are synchronised and edge-detected in the clk domain.
- Exposes rx/tx holding registers, status/control registers and an IRQ to the Nios II data master.

---
 rtl/nios2_spi_pkg.sv | 31 +++
 rtl/nios2_spi_slave_if.sv | 33 +++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/nios2_spi_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_nios2_spi_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/nios2_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nios2_spi_pkg
// Purpose : Register map, status/control bit positions and FSM states for
//           the Nios II SPI slave.
// Rev     : 1.0  initial release
// ============================================================================
package nios2_spi_pkg;

    localparam logic [2:0] RXDATA  = 3'd0;
    localparam logic [2:0] TXDATA  = 3'd1;
    localparam logic [2:0] STATUS  = 3'd2;
    localparam logic [2:0] CONTROL = 3'd3;

    localparam int BIT_ROE  = 3;
    localparam int BIT_TOE  = 4;
    localparam int BIT_TMT  = 5;
    localparam int BIT_TRDY = 6;
    localparam int BIT_RRDY = 7;
    localparam int BIT_E    = 8;

    // Writable control bits: iROE, iTOE, iTRDY, iRRDY, iE
    localparam logic [8:0] CTRL_MASK = 9'h1D8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nios2_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : nios2_spi_slave_if
// Purpose : SPI pins and CPU register port of the SPI slave.
// Rev     : 1.0  initial release
// ============================================================================
interface nios2_spi_slave_if;
    logic        SCLK;
    logic        SS_n;
    logic        MOSI;
    logic        MISO;
    logic        MISO_oe;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    modport slave (
        input  SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
    );

    modport master (
        output SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
    );
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Purpose : Multi-flop synchroniser with rise/fall detection in the clk domain.
// Rev     : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   dly_q, dly_d;
    logic [SYNC_STAGES:0]   vld_q, vld_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
        dly_d   = chain_q[SYNC_STAGES-1];
        vld_d   = {vld_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q   <= RESET_VAL;
            vld_q   <= '0;
        end else begin
            chain_q <= chain_d;
            dly_q   <= dly_d;
            vld_q   <= vld_d;
        end
    end

    // Edges are suppressed until the chain holds real samples, so a line already
    // low when reset releases never looks like a fresh falling edge.
    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = vld_q[SYNC_STAGES] &  sync & ~dly_q;
    assign fall = vld_q[SYNC_STAGES] & ~sync &  dly_q;

endmodule
`default_nettype wire

// File: rtl/nios2_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : nios2_spi_slave
// Purpose : Mode-0 SPI slave with Nios II register port (rx/tx/status/control).
// Rev     : 1.0  initial release
// ============================================================================
module nios2_spi_slave
    import nios2_spi_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    nios2_spi_slave_if.slave  bus
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(bus.SCLK),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(bus.SS_n),
        .sync(ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(bus.MOSI),
        .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_ok;
    assign unused_ok = &{1'b0, sclk_s, ss_rise, mosi_rise, mosi_fall, bus.data_from_cpu[15:9]};

    state_t state_q, state_d;
    logic   start, rx_rise, tx_fall, tx_load, miso_oe;

    logic [DATABITS-1:0] tx_shift_q, tx_shift_d, tx_holding_q, tx_holding_d;
    logic [DATABITS-1:0] rx_shift_q, rx_shift_d, rx_holding_q, rx_holding_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic                tx_primed_q, tx_primed_d, reload_q, reload_d;
    logic                roe_q, roe_d, toe_q, toe_d, rrdy_q, rrdy_d;
    logic [8:0]          ctrl_q, ctrl_d, wdata_q, wdata_d;
    logic [2:0]          addr_q, addr_d;
    logic                rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
    logic                rd_act_q, rd_act_d, wr_act_q, wr_act_d;
    logic                irq_q, irq_d;
    logic [15:0]         rdata_q, rdata_d, status;
    logic                rd_req, wr_req, rd_p1, wr_p1, byte_done, trdy, err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_s)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miso_oe = (state_q == ACTIVE);
        start   = (state_q == IDLE) & ss_fall;
        rx_rise = miso_oe & ~ss_s & sclk_rise;
        tx_fall = miso_oe & ~ss_s & sclk_fall;
        tx_load = start | (tx_fall & reload_q);
    end

    // ---------------- datapath and register port ----------------
    assign rd_req    = bus.spi_select & ~bus.read_n;
    assign wr_req    = bus.spi_select & ~bus.write_n;
    assign rd_p1     = rd_req & ~rd_strobe_q;
    assign wr_p1     = wr_req & ~wr_strobe_q;
    assign byte_done = rx_rise & (bitcnt_q == 4'(DATABITS - 1));
    assign trdy      = ~tx_primed_q;
    assign err       = roe_q | toe_q;

    always_comb begin
        status           = '0;
        status[BIT_ROE]  = roe_q;
        status[BIT_TOE]  = toe_q;
        status[BIT_TMT]  = trdy & (state_q == IDLE);
        status[BIT_TRDY] = trdy;
        status[BIT_RRDY] = rrdy_q;
        status[BIT_E]    = err;
    end

    always_comb begin
        rd_strobe_d  = rd_req;
        wr_strobe_d  = wr_req;
        rd_act_d     = rd_p1;
        wr_act_d     = wr_p1;
        addr_d       = (rd_p1 | wr_p1) ? bus.mem_addr : addr_q;
        wdata_d      = wr_p1 ? bus.data_from_cpu[8:0] : wdata_q;
        tx_shift_d   = tx_shift_q;
        tx_holding_d = tx_holding_q;
        tx_primed_d  = tx_primed_q;
        rx_shift_d   = rx_shift_q;
        rx_holding_d = rx_holding_q;
        bitcnt_d     = bitcnt_q;
        reload_d     = reload_q;
        roe_d        = roe_q;
        toe_d        = toe_q;
        rrdy_d       = rrdy_q;
        ctrl_d       = ctrl_q;

        if (tx_load) begin
            tx_shift_d  = tx_primed_q ? tx_holding_q : '0;
            tx_primed_d = 1'b0;
        end else if (tx_fall) begin
            tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
        end

        // A write landing with a load re-primes: the load already took the old byte.
        if (wr_act_q && addr_q == TXDATA) begin
            if (!tx_primed_q || tx_load) begin
                tx_holding_d = wdata_q[DATABITS-1:0];
                tx_primed_d  = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end

        if (rx_rise) begin
            rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
            bitcnt_d   = bitcnt_q + 4'd1;
        end
        if (tx_fall && reload_q) begin
            bitcnt_d = '0;
            reload_d = 1'b0;
        end
        if (state_q == IDLE) begin
            bitcnt_d = '0;
            reload_d = 1'b0;
        end

        if (rd_act_q && addr_q == RXDATA) rrdy_d = 1'b0;
        if (wr_act_q && addr_q == STATUS) begin
            rrdy_d = 1'b0;
            roe_d  = 1'b0;
            toe_d  = 1'b0;
        end
        if (byte_done) begin
            rx_holding_d = {rx_shift_q[DATABITS-2:0], mosi_s};
            reload_d     = 1'b1;
            rrdy_d       = 1'b1;
            if (rrdy_q) roe_d = 1'b1;
        end

        if (wr_act_q && addr_q == CONTROL) ctrl_d = wdata_q & CTRL_MASK;

        irq_d = (roe_q  & ctrl_q[BIT_ROE])  | (toe_q & ctrl_q[BIT_TOE]) |
                (trdy   & ctrl_q[BIT_TRDY]) | (rrdy_q & ctrl_q[BIT_RRDY]) |
                (err    & ctrl_q[BIT_E]);

        case (bus.mem_addr)
            RXDATA:  rdata_d = {{(16-DATABITS){1'b0}}, rx_holding_q};
            STATUS:  rdata_d = status;
            CONTROL: rdata_d = {7'b0, ctrl_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_strobe_q  <= 1'b0;
            wr_strobe_q  <= 1'b0;
            rd_act_q     <= 1'b0;
            wr_act_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tx_shift_q   <= '0;
            tx_holding_q <= '0;
            tx_primed_q  <= 1'b0;
            rx_shift_q   <= '0;
            rx_holding_q <= '0;
            bitcnt_q     <= '0;
            reload_q     <= 1'b0;
            roe_q        <= 1'b0;
            toe_q        <= 1'b0;
            rrdy_q       <= 1'b0;
            ctrl_q       <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            rd_strobe_q  <= rd_strobe_d;
            wr_strobe_q  <= wr_strobe_d;
            rd_act_q     <= rd_act_d;
            wr_act_q     <= wr_act_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tx_shift_q   <= tx_shift_d;
            tx_holding_q <= tx_holding_d;
            tx_primed_q  <= tx_primed_d;
            rx_shift_q   <= rx_shift_d;
            rx_holding_q <= rx_holding_d;
            bitcnt_q     <= bitcnt_d;
            reload_q     <= reload_d;
            roe_q        <= roe_d;
            toe_q        <= toe_d;
            rrdy_q       <= rrdy_d;
            ctrl_q       <= ctrl_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.MISO          = tx_shift_q[DATABITS-1];
    assign bus.MISO_oe       = miso_oe;
    assign bus.data_to_cpu   = rdata_q;
    assign bus.irq           = irq_q;
    assign bus.dataavailable = rrdy_q;
    assign bus.readyfordata  = trdy;

endmodule
`default_nettype wire

// File: tb/tb_nios2_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios2_spi_slave
// Purpose : Directed self-checking bench: SPI master at clk/16 plus CPU accesses.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nios2_spi_slave;

    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nios2_spi_slave_if bus ();

    nios2_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        bus.spi_select = 1'b1; bus.mem_addr = a; bus.data_from_cpu = d; bus.write_n = 1'b0;
        tick(2);
        bus.spi_select = 1'b0; bus.write_n = 1'b1;
        tick(1);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        bus.spi_select = 1'b1; bus.mem_addr = a; bus.read_n = 1'b0;
        tick(1);
        d = bus.data_to_cpu;
        tick(1);
        bus.spi_select = 1'b0; bus.read_n = 1'b1;
        tick(1);
    endtask

    task automatic ss_low();
        bus.SS_n = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        bus.SS_n = 1'b1;
        tick(8);
    endtask

    // Mode 0: MOSI changes while SCLK is low, MISO is sampled on the rising edge.
    task automatic shift_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            bus.MOSI = tx[7-i];
            tick(8);
            bus.SCLK = 1'b1;
            rx[7-i]  = bus.MISO;
            tick(8);
            bus.SCLK = 1'b0;
        end
        tick(8);
    endtask

    logic [15:0] rd;
    logic [7:0]  so;

    initial begin
        reset_n           = 1'b0;
        bus.SCLK          = 1'b0;
        bus.SS_n          = 1'b1;
        bus.MOSI          = 1'b0;
        bus.spi_select    = 1'b0;
        bus.mem_addr      = 3'd0;
        bus.read_n        = 1'b1;
        bus.write_n       = 1'b1;
        bus.data_from_cpu = 16'h0000;
        tick(3);
        check("rst_miso",    {15'b0, bus.MISO},          16'h0000);
        check("rst_miso_oe", {15'b0, bus.MISO_oe},       16'h0000);
        check("rst_irq",     {15'b0, bus.irq},           16'h0000);
        check("rst_rdata",   bus.data_to_cpu,            16'h0000);
        check("rst_dav",     {15'b0, bus.dataavailable}, 16'h0000);
        reset_n = 1'b1;
        tick(5);
        cpu_read(3'd2, rd); check("idle_status", rd, 16'h0060);
        check("idle_rfd", {15'b0, bus.readyfordata}, 16'h0001);

        // Primed byte out, 0x3C in
        cpu_write(3'd1, 16'h00A5);
        cpu_read(3'd2, rd); check("primed_status", rd, 16'h0000);
        check("primed_rfd", {15'b0, bus.readyfordata}, 16'h0000);
        ss_low(); shift_bits(8'h3C, 8, so); ss_high();
        check("t1_miso", {8'h00, so}, 16'h00A5);
        cpu_read(3'd2, rd); check("t1_status", rd, 16'h00E0);
        check("t1_dav_set", {15'b0, bus.dataavailable}, 16'h0001);
        cpu_read(3'd0, rd); check("t1_rxdata", rd, 16'h003C);
        cpu_read(3'd2, rd); check("t1_status_after_rd", rd, 16'h0060);
        check("t1_dav_clr", {15'b0, bus.dataavailable}, 16'h0000);

        // Back-to-back bytes in one select, overrun with iROE enabled
        cpu_write(3'd3, 16'h0008);
        cpu_read(3'd3, rd); check("t2_control", rd, 16'h0008);
        ss_low();
        shift_bits(8'h11, 8, so);
        check("t2_irq_before", {15'b0, bus.irq}, 16'h0000);
        shift_bits(8'h22, 8, so);
        check("t2_irq_roe", {15'b0, bus.irq}, 16'h0001);
        ss_high();
        cpu_read(3'd2, rd); check("t2_status", rd, 16'h01E8);
        cpu_read(3'd0, rd); check("t2_rxdata", rd, 16'h0022);
        cpu_write(3'd2, 16'h0000);
        tick(2);
        check("t2_irq_cleared", {15'b0, bus.irq}, 16'h0000);
        cpu_write(3'd3, 16'h0000);

        // Double tx write: overrun, first byte kept
        cpu_write(3'd1, 16'h0055);
        cpu_write(3'd1, 16'h0066);
        cpu_read(3'd2, rd); check("t3_status_toe", rd, 16'h0110);
        check("t3_rfd", {15'b0, bus.readyfordata}, 16'h0000);
        ss_low(); shift_bits(8'h99, 8, so); ss_high();
        check("t3_miso", {8'h00, so}, 16'h0055);
        cpu_read(3'd2, rd); check("t3_status_after", rd, 16'h01F0);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, rd); check("t3_status_cleared", rd, 16'h0060);

        // Partial byte discarded, then full byte
        ss_low(); shift_bits(8'hAB, 5, so); ss_high();
        cpu_read(3'd2, rd); check("t4_status_partial", rd, 16'h0060);
        cpu_read(3'd0, rd); check("t4_rxdata_kept", rd, 16'h0099);
        ss_low(); shift_bits(8'hF0, 8, so); ss_high();
        cpu_read(3'd2, rd); check("t4_status_full", rd, 16'h00E0);
        cpu_read(3'd0, rd); check("t4_rxdata", rd, 16'h00F0);

        // Nothing primed: zeros out, TMT only when deselected
        ss_low();
        cpu_read(3'd2, rd); check("t5_status_active", rd, 16'h0040);
        check("t5_miso_oe", {15'b0, bus.MISO_oe}, 16'h0001);
        shift_bits(8'h5A, 8, so); ss_high();
        check("t5_miso", {8'h00, so}, 16'h0000);
        cpu_read(3'd2, rd); check("t5_status_idle", rd, 16'h00E0);
        cpu_read(3'd0, rd); check("t5_rxdata", rd, 16'h005A);

        // Reset in the middle of a transfer
        ss_low(); shift_bits(8'hC3, 4, so);
        reset_n = 1'b0;
        tick(1);
        check("t6_rst_miso",    {15'b0, bus.MISO},          16'h0000);
        check("t6_rst_miso_oe", {15'b0, bus.MISO_oe},       16'h0000);
        check("t6_rst_irq",     {15'b0, bus.irq},           16'h0000);
        check("t6_rst_rdata",   bus.data_to_cpu,            16'h0000);
        check("t6_rst_dav",     {15'b0, bus.dataavailable}, 16'h0000);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        shift_bits(8'h3C, 4, so);
        check("t6_ignored_oe", {15'b0, bus.MISO_oe}, 16'h0000);
        ss_high();
        cpu_read(3'd2, rd); check("t6_status_no_rrdy", rd, 16'h0060);
        ss_low(); shift_bits(8'h7E, 8, so); ss_high();
        cpu_read(3'd2, rd); check("t6_status_fresh", rd, 16'h00E0);
        cpu_read(3'd0, rd); check("t6_rxdata", rd, 16'h007E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
